// File: rtl/systolic_feeder.sv
// Skewed-stream front end for an NxN output-stationary systolic array: job FSM, array clear, done pulse.
// Optional stall counter is built only when FEEDER_STALL_CNT_EN is defined.
module systolic_feeder #(
  parameter int DATA_WIDTH = 4,
  parameter int N          = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] a_col,
  input  logic [N*DATA_WIDTH-1:0] b_row,
  output logic [N*DATA_WIDTH-1:0] left_data,
  output logic [N*DATA_WIDTH-1:0] top_data,
  output logic                    arr_rst,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    stall_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_e;

  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(2 * N - 2);
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] k_len_q, k_len_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
  logic                 arr_rst_q, arr_rst_d;
  logic                 accept;

  assign in_ready = (state_q == STREAM);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign arr_rst  = arr_rst_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_len_d = k_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        beat_cnt_d  = '0;
        drain_cnt_d = '0;
        state_d     = (k_len_q == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + ONE;
          if (beat_cnt_q == k_len_q - ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Hold long enough for the last beat to reach the far-corner PE.
        if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
        else                           drain_cnt_d = drain_cnt_q + ONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    arr_rst_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      arr_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      arr_rst_q   <= arr_rst_d;
    end
  end

  // Lane i carries i+1 register stages, which produces the diagonal wavefront.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_pipe_q [i+1];
    logic [DATA_WIDTH-1:0] a_pipe_d [i+1];
    logic [DATA_WIDTH-1:0] b_pipe_q [i+1];
    logic [DATA_WIDTH-1:0] b_pipe_d [i+1];

    always_comb begin
      a_pipe_d[0] = accept ? a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      b_pipe_d[0] = accept ? b_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      for (int s = 1; s <= i; s++) begin
        a_pipe_d[s] = a_pipe_q[s-1];
        b_pipe_d[s] = b_pipe_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        // NOTE: skew stages are reset so an aborted job cannot leak stale operands into the array.
        for (int s = 0; s <= i; s++) begin
          a_pipe_q[s] <= '0;
          b_pipe_q[s] <= '0;
        end
      end else begin
        for (int s = 0; s <= i; s++) begin
          a_pipe_q[s] <= a_pipe_d[s];
          b_pipe_q[s] <= b_pipe_d[s];
        end
      end
    end

    assign left_data[i*DATA_WIDTH +: DATA_WIDTH] = a_pipe_q[i];
    assign top_data[i*DATA_WIDTH +: DATA_WIDTH]  = b_pipe_q[i];
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == CLEAR)
      stall_cnt_d = '0;
    else if (state_q == STREAM && !in_valid && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
